result_dump_unit: RTL and testbench

//  Read-out counterpart to the program/data preload path. After the processor halts on END, the

---
 rtl/result_dump_unit.sv | 111 +++++++++++
 tb/tb_result_dump_unit.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/result_dump_unit.sv
// result_dump_unit: after halt, streams a RAM window then the register bank over a valid/ready port
module result_dump_unit #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 16,
  parameter int RAM_BASE  = 0,
  parameter int RAM_WORDS = 8,
  parameter int NREGS     = 8
) (
  input  logic              clk1,
  input  logic              start,
  input  logic              halt,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_data,
  output logic              reg_rd,
  output logic [2:0]        reg_sel,
  input  logic [DATA_W-1:0] reg_data,
  output logic [DATA_W-1:0] dout,
  output logic              dout_src,
  output logic [ADDR_W-1:0] dout_idx,
  output logic              dout_valid,
  input  logic              dout_ready,
  output logic              dout_last,
  output logic              busy,
  output logic              done
);
  typedef enum logic [2:0] {S_IDLE, S_RAM, S_REG, S_DRAIN, S_DONE} state_t;
  localparam logic [ADDR_W-1:0] RAM_LAST = ADDR_W'(RAM_WORDS - 1);
  localparam logic [ADDR_W-1:0] REG_LAST = ADDR_W'(NREGS - 1);
  localparam logic [2:0]        SEL_LAST = 3'(NREGS - 1);
  state_t            r_state, w_next;
  logic              r_halt_q;
  logic [ADDR_W-1:0] r_ram_cnt;
  logic [2:0]        r_reg_cnt;
  logic              r_pend_v, r_pend_src;
  logic [ADDR_W-1:0] r_pend_idx;
  logic [DATA_W-1:0] r_fd [2];
  logic              r_fs [2];
  logic [ADDR_W-1:0] r_fi [2];
  logic              r_fl [2];
  logic              r_rp, r_wp;
  logic [1:0]        r_occ;
  logic              w_pop, w_credit, w_head_last;
  assign dout_valid  = r_occ != 2'd0;
  assign w_pop       = dout_valid && dout_ready;
  assign w_head_last = r_fl[r_rp];
  assign w_credit    = 3'(r_occ) + 3'(r_pend_v) - 3'(w_pop) < 3'd2;
  assign busy        = r_state inside {S_RAM, S_REG, S_DRAIN};
  assign done        = r_state == S_DONE;
  assign mem_addr    = mem_rd ? ADDR_W'(RAM_BASE) + r_ram_cnt : '0;
  assign reg_sel     = reg_rd ? r_reg_cnt : 3'd0;
  assign dout        = dout_valid ? r_fd[r_rp] : '0;
  assign dout_src    = dout_valid && r_fs[r_rp];
  assign dout_idx    = dout_valid ? r_fi[r_rp] : '0;
  assign dout_last   = dout_valid && w_head_last;
  // next state and read strobes; a read issues only while the FIFO has room for it
  always_comb begin
    w_next = r_state;
    mem_rd = 1'b0;
    reg_rd = 1'b0;
    case (r_state)
      S_IDLE:  w_next = (halt && !r_halt_q) ? S_RAM : S_IDLE;
      S_RAM: begin
        mem_rd = w_credit;
        w_next = (w_credit && r_ram_cnt == RAM_LAST) ? S_REG : S_RAM;
      end
      S_REG: begin
        reg_rd = w_credit;
        w_next = (w_credit && r_reg_cnt == SEL_LAST) ? S_DRAIN : S_REG;
      end
      S_DRAIN: w_next = (w_pop && w_head_last) ? S_DONE : S_DRAIN;
      S_DONE:  w_next = halt ? S_DONE : S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end
  // control state: FSM, halt edge detect, issue counters, in-flight read and FIFO pointers
  always_ff @(posedge clk1 or posedge start) begin
    if (start) begin
      r_state    <= S_IDLE;
      r_halt_q   <= 1'b0;
      r_ram_cnt  <= '0;
      r_reg_cnt  <= 3'd0;
      r_pend_v   <= 1'b0;
      r_pend_src <= 1'b0;
      r_pend_idx <= '0;
      r_rp       <= 1'b0;
      r_wp       <= 1'b0;
      r_occ      <= 2'd0;
    end else begin
      r_state    <= w_next;
      r_halt_q   <= halt;
      r_ram_cnt  <= mem_rd ? (r_ram_cnt == RAM_LAST ? '0 : r_ram_cnt + 1'b1) : r_ram_cnt;
      r_reg_cnt  <= reg_rd ? (r_reg_cnt == SEL_LAST ? 3'd0 : r_reg_cnt + 3'd1) : r_reg_cnt;
      r_pend_v   <= mem_rd || reg_rd;
      r_pend_src <= reg_rd;
      r_pend_idx <= reg_rd ? ADDR_W'(r_reg_cnt) : r_ram_cnt;
      r_rp       <= r_rp ^ w_pop;
      r_wp       <= r_wp ^ r_pend_v;
      r_occ      <= r_occ + 2'(r_pend_v) - 2'(w_pop);
    end
  end
  // FIFO storage: the word returned for last cycle's strobe is captured with its tag
  always_ff @(posedge clk1) begin
    if (r_pend_v) begin
      r_fd[r_wp] <= r_pend_src ? reg_data : mem_data;
      r_fs[r_wp] <= r_pend_src;
      r_fi[r_wp] <= r_pend_idx;
      r_fl[r_wp] <= r_pend_src && r_pend_idx == REG_LAST;
    end
  end
endmodule

// File: tb/tb_result_dump_unit.sv
// tb_result_dump_unit: checks the dump stream against a table and a queue-based model
`timescale 1ns/1ps
module tb_result_dump_unit;
  typedef struct packed {
    logic [31:0] d;
    logic        s;
    logic [15:0] i;
    logic        l;
  } beat_t;
  logic        clk1 = 0, start = 1, halt = 0, dout_ready = 1, b_dout_ready = 1;
  logic        mem_rd, reg_rd, dout_src, dout_valid, dout_last, busy, done;
  logic [15:0] mem_addr, dout_idx;
  logic [2:0]  reg_sel;
  logic [31:0] mem_data, reg_data, dout;
  logic        b_mem_rd, b_reg_rd, b_dout_src, b_dout_valid, b_dout_last, b_busy, b_done;
  logic [15:0] b_mem_addr, b_dout_idx;
  logic [2:0]  b_reg_sel;
  logic [31:0] b_mem_data, b_reg_data, b_dout;
  logic [31:0] ram [16];
  logic [31:0] regs [8];
  logic [15:0] rd_log [256];
  int          rd_cnt = 0;
  int          checks = 0, errors = 0;
  beat_t       tab1 [14];
  beat_t       exp_q [$];
  always #5 clk1 = ~clk1;
  result_dump_unit #(.RAM_WORDS(6)) dut (
    .clk1(clk1), .start(start), .halt(halt), .mem_rd(mem_rd), .mem_addr(mem_addr),
    .mem_data(mem_data), .reg_rd(reg_rd), .reg_sel(reg_sel), .reg_data(reg_data),
    .dout(dout), .dout_src(dout_src), .dout_idx(dout_idx), .dout_valid(dout_valid),
    .dout_ready(dout_ready), .dout_last(dout_last), .busy(busy), .done(done));
  result_dump_unit #(.RAM_BASE(4), .RAM_WORDS(2), .NREGS(1)) dut2 (
    .clk1(clk1), .start(start), .halt(halt), .mem_rd(b_mem_rd), .mem_addr(b_mem_addr),
    .mem_data(b_mem_data), .reg_rd(b_reg_rd), .reg_sel(b_reg_sel), .reg_data(b_reg_data),
    .dout(b_dout), .dout_src(b_dout_src), .dout_idx(b_dout_idx), .dout_valid(b_dout_valid),
    .dout_ready(b_dout_ready), .dout_last(b_dout_last), .busy(b_busy), .done(b_done));
  always @(posedge clk1) begin
    mem_data   <= mem_rd ? ram[mem_addr[3:0]] : 32'hDEADBEEF;
    reg_data   <= reg_rd ? regs[reg_sel] : 32'hDEADBEEF;
    b_mem_data <= b_mem_rd ? ram[b_mem_addr[3:0]] : 32'hDEADBEEF;
    b_reg_data <= b_reg_rd ? regs[b_reg_sel] : 32'hDEADBEEF;
    if (mem_rd) begin
      rd_log[rd_cnt % 256] <= mem_addr;
      rd_cnt <= rd_cnt + 1;
    end
  end
  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, a, e);
    end
  endtask
  function automatic beat_t cur(input bit w);
    return w ? beat_t'({b_dout, b_dout_src, b_dout_idx, b_dout_last})
             : beat_t'({dout, dout_src, dout_idx, dout_last});
  endfunction
  function automatic void build(input int base, input int nram, input int nreg);
    exp_q.delete();
    for (int i = 0; i < nram; i++) exp_q.push_back({ram[base + i], 1'b0, 16'(i), 1'b0});
    for (int j = 0; j < nreg; j++) exp_q.push_back({regs[j], 1'b1, 16'(j), 1'(j == nreg - 1)});
  endfunction
  function automatic void load_tab();
    exp_q.delete();
    for (int i = 0; i < 14; i++) exp_q.push_back(tab1[i]);
  endfunction
  function automatic void load_spec();
    for (int i = 0; i < 16; i++) ram[i] = i < 6 ? tab1[i].d : 32'(1000 + i);
    for (int j = 0; j < 8; j++) regs[j] = 32'(100 + j);
  endfunction
  // mode 0: ready high, 1: toggling, 2: random; stops after stop_after beats
  task automatic collect(input bit w, input int mode, input int nbeats, input int stop_after,
                         input bit chk_lat, input bit glitch);
    int k = 0, c = 0, first = -1, lastc = 0;
    bit stall = 0, rdy, v;
    beat_t held, b;
    while (k < stop_after && c < 400) begin
      @(negedge clk1);
      c++;
      if (glitch && c == 6) halt = 0;
      if (glitch && c == 7) halt = 1;
      rdy = mode == 0 ? 1'b1 : mode == 1 ? 1'(c % 2) : ($urandom_range(0, 2) != 0);
      if (w) b_dout_ready = rdy; else dout_ready = rdy;
      v = w ? b_dout_valid : dout_valid;
      b = cur(w);
      if (stall) chk("stall_stable", {v, b}, {1'b1, held});
      if (v && first < 0) first = c;
      if (v && rdy) begin
        chk($sformatf("beat%0d", k), b, k < exp_q.size() ? exp_q[k] : '0);
        if (mode == 0 && k > 0) chk("no_bubble", c - lastc, 1);
        lastc = c;
        k++;
      end
      stall = v && !rdy;
      held = b;
    end
    if (k < stop_after) chk("beat_timeout", k, stop_after);
    if (chk_lat) chk("first_valid_latency", first, 3);
    if (stop_after == nbeats) begin
      @(negedge clk1);
      if (w) chk("done_after", {b_done, b_busy, b_dout_valid}, 3'b100);
      else chk("done_after", {done, busy, dout_valid}, 3'b100);
    end
  endtask
  task automatic rise();
    @(negedge clk1);
    halt = 1;
  endtask
  task automatic release_halt();
    @(negedge clk1);
    halt = 0;
    repeat (2) @(negedge clk1);
    chk("done_clears", {done, busy}, 2'b00);
  endtask
  task automatic chk_zero(input string n);
    chk({n, "_ctl"}, {mem_rd, mem_addr, reg_rd, reg_sel, dout_src, dout_valid, dout_last, busy, done}, 0);
    chk({n, "_data"}, {dout, dout_idx}, 0);
  endtask
  initial begin
    int r6 [6];
    int base;
    r6 = '{7, 2, 9, 14, 45, 23};
    for (int i = 0; i < 14; i++)
      tab1[i] = i < 6 ? beat_t'({32'(r6[i]), 1'b0, 16'(i), 1'b0})
                      : beat_t'({32'(100 + i - 6), 1'b1, 16'(i - 6), 1'(i == 13)});
    load_spec();
    repeat (3) @(negedge clk1);
    chk_zero("reset");
    start = 0;
    load_tab();
    rise();
    collect(0, 0, 14, 14, 1, 0);
    release_halt();
    rise();
    collect(0, 1, 14, 14, 1, 0);
    release_halt();
    @(negedge clk1);
    dout_ready = 0;
    base = rd_cnt;
    halt = 1;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk1);
      if (c >= 3) chk("stall_hold", {dout_valid, dout}, {1'b1, 32'd7});
    end
    chk("stall_reads", rd_cnt - base, 2);
    chk("stall_addr0", rd_log[base % 256], 0);
    chk("stall_addr1", rd_log[(base + 1) % 256], 1);
    collect(0, 0, 14, 14, 0, 0);
    release_halt();
    rise();
    collect(0, 0, 14, 3, 1, 0);
    @(negedge clk1);
    chk("pre_abort_dout", dout, 14);
    start = 1;
    halt = 0;
    #1 chk_zero("abort");
    @(negedge clk1);
    start = 0;
    rise();
    collect(0, 0, 14, 14, 1, 0);
    base = rd_cnt;
    repeat (10) @(negedge clk1);
    chk("no_redump", {done, busy, dout_valid, 32'(rd_cnt - base)}, {3'b100, 32'd0});
    release_halt();
    rise();
    collect(0, 0, 14, 14, 1, 1);
    release_halt();
    for (int it = 0; it < 4; it++) begin
      for (int i = 0; i < 16; i++) ram[i] = $urandom;
      for (int j = 0; j < 8; j++) regs[j] = $urandom;
      build(0, 6, 8);
      rise();
      collect(0, 2, 14, 14, 1, 0);
      release_halt();
    end
    load_spec();
    dout_ready = 1;
    exp_q.delete();
    exp_q.push_back({32'd45, 1'b0, 16'd0, 1'b0});
    exp_q.push_back({32'd23, 1'b0, 16'd1, 1'b0});
    exp_q.push_back({32'd100, 1'b1, 16'd0, 1'b1});
    rise();
    collect(1, 0, 3, 3, 1, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
